pht_port_scheduler: RTL

Owns the single-ported pattern history table (PHT) of 2-bit saturating branch counters. It shares the one array port between fetch-stage prediction lookups and execute-stage resolution updates. Updates are buffered in a small FIFO and applied as read-modify-write sequences. After reset, the block sweeps the whole table to a known state.

---
 rtl/pht_pkg.sv | 19 +
 rtl/pht_update_fifo.sv | 48 ++++
 rtl/pht_port_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pht_pkg.sv
// Shared definitions for the PHT port scheduler: counter encodings,
// controller state constants and the saturating counter update.
package pht_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] CTL_INIT = 2'd0;
  localparam logic [1:0] CTL_IDLE = 2'd1;
  localparam logic [1:0] CTL_WR   = 2'd2;

  function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
    if (taken) return (state == ST) ? ST : state + 2'd1;
    return (state == SNT) ? SNT : state - 2'd1;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Synchronous FIFO of pending {index, taken} updates; head is the oldest entry.
// Push while full and pop while empty are ignored; reset flushes all entries.
module pht_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/pht_port_scheduler.sv
// Single-ported PHT shared between fetch lookups and buffered RMW updates, with init sweep.
// Optional PHT_PERF_EN adds saturating lookup/update/stall counters.
module pht_port_scheduler #(
  parameter int         INDEX_W    = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lk_valid,
  input  logic [INDEX_W-1:0] lk_index,
  output logic               lk_ready,
  output logic               pred_valid,
  output logic [1:0]         pred_state,
  output logic               pred_taken,
  input  logic               up_valid,
  input  logic [INDEX_W-1:0] up_index,
  input  logic               up_taken,
  output logic               up_ready,
  output logic               init_busy
`ifdef PHT_PERF_EN
  ,
  output logic [15:0]        perf_lookups,
  output logic [15:0]        perf_updates,
  output logic [15:0]        perf_stall
`endif
);

  import pht_pkg::*;

  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0]         tbl [ENTRIES];
  logic [1:0]         ctl;
  logic [INDEX_W-1:0] init_idx;
  logic [1:0]         rd_state;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INDEX_W:0]   fifo_head;
  logic [INDEX_W-1:0] head_idx;
  logic               head_taken;
  logic               drain_rd;
  logic               lk_grant;
  logic               up_push;
  logic               wb;

  assign head_idx   = fifo_head[INDEX_W:1];
  assign head_taken = fifo_head[0];
  assign lk_ready   = (ctl == CTL_IDLE) && !fifo_full;
  assign up_ready   = (ctl != CTL_INIT) && !fifo_full;
  assign up_push    = up_valid && up_ready;
  assign wb         = (ctl == CTL_WR);
  assign init_busy  = (ctl == CTL_INIT);
  assign pred_taken = pred_state[1];

  // A full FIFO outranks lookups so updates cannot be starved forever.
  always_comb begin
    drain_rd = 1'b0;
    lk_grant = 1'b0;
    if (ctl == CTL_IDLE) begin
      if (fifo_full)       drain_rd = 1'b1;
      else if (lk_valid)   lk_grant = 1'b1;
      else if (!fifo_empty) drain_rd = 1'b1;
    end
  end

  pht_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INDEX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (up_push),
    .wdata ({up_index, up_taken}),
    .pop   (wb),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Reset suppresses the write so an in-flight RMW is aborted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ctl == CTL_INIT) tbl[init_idx] <= INIT_STATE;
      else if (wb)         tbl[head_idx] <= sat_next(rd_state, head_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl        <= CTL_INIT;
      init_idx   <= '0;
      rd_state   <= SNT;
      pred_valid <= 1'b0;
      pred_state <= SNT;
    end else begin
      pred_valid <= lk_grant;
      if (lk_grant) pred_state <= tbl[lk_index];
      case (ctl)
        CTL_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == {INDEX_W{1'b1}}) ctl <= CTL_IDLE;
        end
        CTL_IDLE: begin
          if (drain_rd) begin
            rd_state <= tbl[head_idx];
            ctl      <= CTL_WR;
          end
        end
        CTL_WR:  ctl <= CTL_IDLE;
        default: ctl <= CTL_INIT;
      endcase
    end
  end

`ifdef PHT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lookups <= '0;
      perf_updates <= '0;
      perf_stall   <= '0;
    end else begin
      if (lk_valid && lk_ready && perf_lookups != 16'hFFFF) perf_lookups <= perf_lookups + 16'd1;
      if (wb && perf_updates != 16'hFFFF)                   perf_updates <= perf_updates + 16'd1;
      if (lk_valid && !lk_ready && perf_stall != 16'hFFFF)  perf_stall   <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
